// File: rtl/irq_controller_if.sv
// Signal bundle between the IRQ controller, its upstream priority encoder and the CPU.
// master drives requests and CPU handshakes; slave is the controller side.
interface irq_controller_if;
  logic        irq_in;
  logic [1:0]  irq_id;
  logic        int_en;
  logic [3:0]  mask;
  logic        cpu_ack;
  logic        cpu_eoi;
  logic        ovr_clr;
  logic        cpu_irq;
  logic [31:0] vector_addr;
  logic [1:0]  cur_id;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  overrun;

  modport master (
    output irq_in, irq_id, int_en, mask, cpu_ack, cpu_eoi, ovr_clr,
    input  cpu_irq, vector_addr, cur_id, in_service, pending, overrun
  );

  modport slave (
    input  irq_in, irq_id, int_en, mask, cpu_ack, cpu_eoi, ovr_clr,
    output cpu_irq, vector_addr, cur_id, in_service, pending, overrun
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-captured pending latch plus a non-nesting IDLE/REQ/SERVICE request FSM
// offering the lowest unmasked pending source to the CPU with its vector address.
module irq_controller #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input logic              clk,
  input logic              rst,
  irq_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t      state_q, state_n;
  logic        irq_prev_q;
  logic        cpu_irq_q, cpu_irq_n;
  logic        in_service_q, in_service_n;
  logic [1:0]  cur_id_q, cur_id_n;
  logic [31:0] vector_addr_q, vector_addr_n;
  logic [3:0]  pending_q, pending_n;
  logic [3:0]  overrun_q, overrun_n;

  logic        capture;
  logic        found;
  logic [1:0]  sel_id;
  logic        clr_cur;

  assign capture = bus.irq_in & ~irq_prev_q;

  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!found && pending_q[i] && !bus.mask[i]) begin
        found  = 1'b1;
        sel_id = 2'(i);
      end
    end
  end

  always_comb begin
    state_n       = state_q;
    cpu_irq_n     = cpu_irq_q;
    in_service_n  = in_service_q;
    cur_id_n      = cur_id_q;
    vector_addr_n = vector_addr_q;
    clr_cur       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.int_en && found) begin
          state_n       = REQ;
          cpu_irq_n     = 1'b1;
          cur_id_n      = sel_id;
          vector_addr_n = VEC_BASE + 32'(sel_id) * VEC_STRIDE;
        end
      end
      REQ: begin
        // Acknowledge takes precedence over a withdrawal in the same cycle.
        if (bus.cpu_ack) begin
          state_n      = SERVICE;
          cpu_irq_n    = 1'b0;
          in_service_n = 1'b1;
          clr_cur      = 1'b1;
        end else if (!bus.int_en || bus.mask[cur_id_q]) begin
          state_n   = IDLE;
          cpu_irq_n = 1'b0;
        end
      end
      SERVICE: begin
        if (bus.cpu_eoi) begin
          state_n      = IDLE;
          in_service_n = 1'b0;
        end
      end
      default: begin
        state_n      = IDLE;
        cpu_irq_n    = 1'b0;
        in_service_n = 1'b0;
      end
    endcase
  end

  // A capture applied after the acknowledge clear lets a same-cycle event survive.
  always_comb begin
    pending_n = pending_q;
    overrun_n = bus.ovr_clr ? '0 : overrun_q;
    if (clr_cur)
      pending_n[cur_id_q] = 1'b0;
    if (capture) begin
      if (pending_q[bus.irq_id])
        overrun_n[bus.irq_id] = 1'b1;
      pending_n[bus.irq_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      irq_prev_q    <= 1'b0;
      cpu_irq_q     <= 1'b0;
      in_service_q  <= 1'b0;
      cur_id_q      <= '0;
      vector_addr_q <= VEC_BASE;
      pending_q     <= '0;
      overrun_q     <= '0;
    end else begin
      state_q       <= state_n;
      irq_prev_q    <= bus.irq_in;
      cpu_irq_q     <= cpu_irq_n;
      in_service_q  <= in_service_n;
      cur_id_q      <= cur_id_n;
      vector_addr_q <= vector_addr_n;
      pending_q     <= pending_n;
      overrun_q     <= overrun_n;
    end
  end

  assign bus.cpu_irq     = cpu_irq_q;
  assign bus.in_service  = in_service_q;
  assign bus.cur_id      = cur_id_q;
  assign bus.vector_addr = vector_addr_q;
  assign bus.pending     = pending_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed-vector bench for irq_controller: capture, priority, mask/enable,
// overrun, simultaneous set/clear and reset during service.
module tb_irq_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  irq_controller_if bus();

  irq_controller #(
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0010)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.irq_in  = 1'b0;
    bus.irq_id  = 2'd0;
    bus.int_en  = 1'b1;
    bus.mask    = 4'b0000;
    bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b0;
    bus.ovr_clr = 1'b0;

    // Reset state
    rst = 1'b1;
    step(); step();
    check("rst_cpu_irq", 32'(bus.cpu_irq), 32'd0);
    check("rst_in_svc",  32'(bus.in_service), 32'd0);
    check("rst_cur_id",  32'(bus.cur_id), 32'd0);
    check("rst_vec",     bus.vector_addr, 32'h100);
    check("rst_pending", 32'(bus.pending), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;

    // Single event on id 2
    bus.irq_in = 1'b1; bus.irq_id = 2'd2; step();
    bus.irq_in = 1'b0;
    check("t1_pending", 32'(bus.pending), 32'b0100);
    check("t1_irq_early", 32'(bus.cpu_irq), 32'd0);
    step();
    check("t1_cpu_irq", 32'(bus.cpu_irq), 32'd1);
    check("t1_cur_id",  32'(bus.cur_id), 32'd2);
    check("t1_vec",     bus.vector_addr, 32'h120);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    check("t1_ack_pending", 32'(bus.pending), 32'd0);
    check("t1_ack_in_svc",  32'(bus.in_service), 32'd1);
    check("t1_ack_cpu_irq", 32'(bus.cpu_irq), 32'd0);
    step();
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    check("t1_eoi_in_svc", 32'(bus.in_service), 32'd0);
    step();
    check("t1_idle_irq", 32'(bus.cpu_irq), 32'd0);

    // Priority: id 3 then id 1 arrive while servicing id 0
    bus.irq_in = 1'b1; bus.irq_id = 2'd0; step();
    bus.irq_in = 1'b0; step();
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    bus.irq_in = 1'b1; bus.irq_id = 2'd3; step();
    bus.irq_in = 1'b0; step();
    bus.irq_in = 1'b1; bus.irq_id = 2'd1; step();
    bus.irq_in = 1'b0; step();
    check("t2_pending",  32'(bus.pending), 32'b1010);
    check("t2_nonest",   32'(bus.cpu_irq), 32'd0);
    check("t2_in_svc",   32'(bus.in_service), 32'd1);
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    step();
    check("t2_cur_id1", 32'(bus.cur_id), 32'd1);
    check("t2_vec1",    bus.vector_addr, 32'h110);
    check("t2_irq1",    32'(bus.cpu_irq), 32'd1);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    step();
    check("t2_cur_id3", 32'(bus.cur_id), 32'd3);
    check("t2_vec3",    bus.vector_addr, 32'h130);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    step();
    check("t2_drained", 32'(bus.pending), 32'd0);

    // Mask and enable
    bus.mask = 4'b0001;
    bus.irq_in = 1'b1; bus.irq_id = 2'd0; step();
    bus.irq_in = 1'b0; step(); step();
    check("t3_masked_irq", 32'(bus.cpu_irq), 32'd0);
    check("t3_masked_pend", 32'(bus.pending), 32'b0001);
    bus.mask = 4'b0000; step();
    check("t3_unmask_irq", 32'(bus.cpu_irq), 32'd1);
    bus.int_en = 1'b0; step();
    check("t3_dis_irq",  32'(bus.cpu_irq), 32'd0);
    check("t3_dis_pend", 32'(bus.pending), 32'b0001);
    bus.int_en = 1'b1; step();
    check("t3_reen_irq", 32'(bus.cpu_irq), 32'd1);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;

    // Overrun, clear, and set-wins-over-clear
    bus.irq_in = 1'b1; bus.irq_id = 2'd1; step();
    bus.irq_in = 1'b0; step();
    bus.irq_in = 1'b1; step();
    bus.irq_in = 1'b0;
    check("t4_overrun", 32'(bus.overrun), 32'b0010);
    check("t4_pending", 32'(bus.pending), 32'b0010);
    bus.ovr_clr = 1'b1; step();
    check("t4_ovr_clr", 32'(bus.overrun), 32'd0);
    bus.irq_in = 1'b1; step();
    check("t4_set_wins", 32'(bus.overrun), 32'b0010);
    bus.irq_in = 1'b0; step();
    bus.ovr_clr = 1'b0;
    check("t4_ovr_clr2", 32'(bus.overrun), 32'd0);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    step();

    // Capture on cur_id in the same cycle as its acknowledge
    bus.irq_in = 1'b1; bus.irq_id = 2'd0; step();
    bus.irq_in = 1'b0; step();
    check("t5_req_cur", 32'(bus.cur_id), 32'd0);
    bus.irq_in = 1'b1; bus.cpu_ack = 1'b1; step();
    bus.irq_in = 1'b0; bus.cpu_ack = 1'b0;
    check("t5_pend_kept", 32'(bus.pending), 32'b0001);
    check("t5_in_svc",    32'(bus.in_service), 32'd1);
    bus.cpu_eoi = 1'b1; step(); bus.cpu_eoi = 1'b0;
    step();
    check("t5_reoffer", 32'(bus.cpu_irq), 32'd1);

    // Reset during SERVICE with irq_in held high across it
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    bus.irq_in = 1'b1; bus.irq_id = 2'd2; step();
    rst = 1'b1; step();
    check("t6_cpu_irq", 32'(bus.cpu_irq), 32'd0);
    check("t6_in_svc",  32'(bus.in_service), 32'd0);
    check("t6_cur_id",  32'(bus.cur_id), 32'd0);
    check("t6_vec",     bus.vector_addr, 32'h100);
    check("t6_pending", 32'(bus.pending), 32'd0);
    check("t6_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0; step();
    check("t6_recapture", 32'(bus.pending), 32'b0100);
    step();
    check("t6_irq", 32'(bus.cpu_irq), 32'd1);
    check("t6_vec2", bus.vector_addr, 32'h120);
    bus.cpu_ack = 1'b1; step(); bus.cpu_ack = 1'b0;
    step(); step();
    check("t6_held_once", 32'(bus.pending), 32'd0);
    check("t6_ovr_none",  32'(bus.overrun), 32'd0);
    bus.irq_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
